// File: rtl/board_mem_clear.sv
// board_mem_clear: playfield occupancy bitmap with a collision read port,
// a single-cell lock write port, a registered VGA scan port and a
// bottom-up full-row clear engine that reports how many rows it removed.
module board_mem_clear #(
   parameter int COLS = 10,
   parameter int ROWS = 20
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] board_rx,
   input  logic [4:0] board_ry,
   output logic       board_rdata,
   input  logic       board_we,
   input  logic [3:0] board_wx,
   input  logic [4:0] board_wy,
   input  logic       board_wdata,
   input  logic [3:0] vga_x,
   input  logic [4:0] vga_y,
   output logic       vga_cell,
   input  logic       clear_start,
   output logic       clear_busy,
   output logic       clear_done,
   output logic [4:0] lines_cleared
);

   localparam logic [3:0] COLS_W = 4'(COLS);
   localparam logic [4:0] ROWS_W = 5'(ROWS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state;
   logic [COLS-1:0]  rows_q [ROWS];
   logic [4:0]       r_ptr;
   logic [4:0]       s_ptr;
   logic [4:0]       cnt;

   logic rd_in_range;
   logic wr_in_range;
   logic vga_in_range;

   // Address range decode for the three ports; anything outside the board is a wall.
   always_comb begin
      rd_in_range  = (board_rx < COLS_W) && (board_ry < ROWS_W);
      wr_in_range  = (board_wx < COLS_W) && (board_wy < ROWS_W);
      vga_in_range = (vga_x < COLS_W) && (vga_y < ROWS_W);
      board_rdata  = 1'b1;
      if (rd_in_range) begin
         board_rdata = rows_q[board_ry][board_rx];
      end
   end

   // Storage, VGA scan register and the row-clear sweep FSM.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rows_q        <= '{default: '0};
         state         <= S_IDLE;
         r_ptr         <= '0;
         s_ptr         <= '0;
         cnt           <= '0;
         vga_cell      <= 1'b0;
         clear_busy    <= 1'b0;
         clear_done    <= 1'b0;
         lines_cleared <= '0;
      end else begin
         vga_cell   <= vga_in_range ? rows_q[vga_y][vga_x] : 1'b0;
         clear_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (board_we && wr_in_range) begin
                  rows_q[board_wy][board_wx] <= board_wdata;
               end
               if (clear_start) begin
                  r_ptr      <= ROWS_W - 5'd1;
                  cnt        <= '0;
                  state      <= S_CHECK;
                  clear_busy <= 1'b1;
               end
            end

            S_CHECK: begin
               if (&rows_q[r_ptr]) begin
                  if (cnt < ROWS_W) begin
                     cnt <= cnt + 5'd1;
                  end
                  s_ptr <= r_ptr;
                  state <= S_SHIFT;
               end else if (r_ptr == 5'd0) begin
                  // Done pulse and count are loaded on entry so both are
                  // visible together during the DONE cycle.
                  state         <= S_DONE;
                  clear_done    <= 1'b1;
                  lines_cleared <= cnt;
               end else begin
                  r_ptr <= r_ptr - 5'd1;
               end
            end

            S_SHIFT: begin
               if (s_ptr != 5'd0) begin
                  rows_q[s_ptr] <= rows_q[s_ptr - 5'd1];
                  s_ptr         <= s_ptr - 5'd1;
               end else begin
                  rows_q[0] <= '0;
                  state     <= S_CHECK;
               end
            end

            S_DONE: begin
               state      <= S_IDLE;
               clear_busy <= 1'b0;
            end

            default: begin
               state      <= S_IDLE;
               clear_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
